tm1638_display_pager: RTL and testbench

//  Front-panel controller placed ahead of tm1638_keys_display_encoded. Selects one of N_PAGES display

---
 rtl/tm1638_pkg.sv | 25 ++
 rtl/tm1638_key_debounce.sv | 60 ++++++
 rtl/tm1638_display_pager.sv | 225 ++++++++++++++++++++++
 tb/tb_tm1638_display_pager.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_pkg.sv
// -----------------------------------------------------------------------------
// tm1638_pkg
// Shared definitions for the TM1638 front-panel pager: key bit positions in
// the debounced key vector, brightness ceiling and the page-seek FSM states.
// -----------------------------------------------------------------------------
package tm1638_pkg;

   // Bit positions of the panel keys the pager consumes.
   localparam int KEY_NEXT   = 0;
   localparam int KEY_PREV   = 1;
   localparam int KEY_DIM    = 2;
   localparam int KEY_BRIGHT = 3;
   localparam int KEY_OFF    = 4;
   localparam int KEY_ROT    = 5;

   // Highest brightness code accepted by the display driver.
   localparam logic [2:0] LEVEL_MAX = 3'd7;

   // Page-seek FSM.
   typedef enum logic {
      ST_IDLE,
      ST_SEEK
   } state_e;

endpackage : tm1638_pkg

// File: rtl/tm1638_key_debounce.sv
// -----------------------------------------------------------------------------
// tm1638_key_debounce
// Debounces a raw key vector as a whole: the vector must stay unchanged for
// DEBOUNCE_CYCLES consecutive samples before it is copied to the stable
// vector. Emits a registered one-cycle pulse for every rising bit of the
// stable vector.
//
// Ports
//   clk_i       system clock
//   rst_ni      synchronous active-low reset
//   keys_raw_i  raw key vector from the TM1638 scan
//   press_o     one-cycle pulse per debounced rising edge
// -----------------------------------------------------------------------------
module tm1638_key_debounce #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] keys_raw_i,
   output logic [WIDTH-1:0] press_o
);

   localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sample_q;
   logic [WIDTH-1:0] stable_q;
   logic [WIDTH-1:0] stable_prev_q;
   logic [WIDTH-1:0] press_q;
   logic [CNT_W-1:0] cnt_q;

   // NOTE: every register here is updated with <= so all of them see the
   // values from before the clock edge; blocking = would let stable_prev_q
   // pick up the new stable_q and swallow the edge pulse.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sample_q      <= '0;
         stable_q      <= '0;
         stable_prev_q <= '0;
         press_q       <= '0;
         cnt_q         <= '0;
      end else begin
         sample_q <= keys_raw_i;
         if (keys_raw_i != sample_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            // Counter saturates; the stable copy keeps tracking the settled input.
            stable_q <= keys_raw_i;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         stable_prev_q <= stable_q;
         press_q       <= stable_q & ~stable_prev_q;
      end
   end

   assign press_o = press_q;

endmodule : tm1638_key_debounce

// File: rtl/tm1638_display_pager.sv
// -----------------------------------------------------------------------------
// tm1638_display_pager
// Front-panel controller in front of the TM1638 display driver. Selects one of
// N_PAGES display pages either from the next/prev keys or from an auto-rotate
// timer, skipping pages whose page_valid bit is low. Owns brightness and
// on/off state and forwards debounced presses of keys 6 and 7.
//
// Configuration macro: TM1638_PAGER_INDICATOR_EN
//   defined   - leds_red shows one-hot(page_sel) for page_sel < 8, leds_green[7]
//               lights while auto-rotate is on.
//   undefined - LEDs pass the selected page through unchanged.
//
// Ports
//   clk_1MHz         system clock
//   rst              synchronous active-low reset
//   keys_raw         raw key vector from the TM1638 scan
//   page_value       32 bits per page, page p at [32p+31:32p]
//   page_dots        decimal points per page (8 bits each)
//   page_leds_green  green LEDs per page (8 bits each)
//   page_leds_red    red LEDs per page (8 bits each)
//   page_valid       page p may be selected
//   display_off      display blanking to the driver
//   display_level    brightness 0..7 to the driver
//   display_value    selected page value (registered)
//   dots             selected page dots (registered)
//   leds_green       selected page green LEDs (registered)
//   leds_red         selected page red LEDs (registered)
//   page_sel         current page index
//   key_press        debounced press pulses, bits 0..5 consumed here (always 0)
// -----------------------------------------------------------------------------
module tm1638_display_pager
   import tm1638_pkg::*;
#(
   parameter int N_PAGES         = 4,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int ROTATE_CYCLES   = 3000000,
   parameter int DEFAULT_LEVEL   = 3
) (
   input  logic                         clk_1MHz,
   input  logic                         rst,
   input  logic [7:0]                   keys_raw,
   input  logic [32*N_PAGES-1:0]        page_value,
   input  logic [8*N_PAGES-1:0]         page_dots,
   input  logic [8*N_PAGES-1:0]         page_leds_green,
   input  logic [8*N_PAGES-1:0]         page_leds_red,
   input  logic [N_PAGES-1:0]           page_valid,
   output logic                         display_off,
   output logic [2:0]                   display_level,
   output logic [31:0]                  display_value,
   output logic [7:0]                   dots,
   output logic [7:0]                   leds_green,
   output logic [7:0]                   leds_red,
   output logic [$clog2(N_PAGES)-1:0]   page_sel,
   output logic [7:0]                   key_press
);

   localparam int               SEL_W    = $clog2(N_PAGES);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_PAGES - 1);
   localparam int               ROT_W    = (ROTATE_CYCLES > 1) ? $clog2(ROTATE_CYCLES) : 1;
   localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROTATE_CYCLES - 1);

   // Modulo-N_PAGES step, correct for non-power-of-two page counts.
   function automatic logic [SEL_W-1:0] step_page(input logic [SEL_W-1:0] idx,
                                                  input logic             down);
      if (down) return (idx == '0) ? SEL_LAST : idx - SEL_W'(1);
      else      return (idx == SEL_LAST) ? '0 : idx + SEL_W'(1);
   endfunction

   // ---------------------------------------------------------------- keys
   logic [7:0] press;

   tm1638_key_debounce #(
      .WIDTH           (8),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk_i      (clk_1MHz),
      .rst_ni     (rst),
      .keys_raw_i (keys_raw),
      .press_o    (press)
   );

   // Opposing keys pressed in the same cycle cancel each other.
   logic next_req, prev_req, dim_req, bright_req;
   assign next_req   = press[KEY_NEXT]   & ~press[KEY_PREV];
   assign prev_req   = press[KEY_PREV]   & ~press[KEY_NEXT];
   assign dim_req    = press[KEY_DIM]    & ~press[KEY_BRIGHT];
   assign bright_req = press[KEY_BRIGHT] & ~press[KEY_DIM];

   assign key_press = {press[7:6], 6'b0};

   // ------------------------------------------------- level / off / rotate
   logic [2:0] level_q, level_d;
   logic       off_q;
   logic       rot_on_q;

   // NOTE: level_d gets its default before any branch so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      level_d = level_q;
      if (dim_req && level_q != 3'd0) begin
         level_d = level_q - 3'd1;
      end else if (bright_req && level_q != LEVEL_MAX) begin
         level_d = level_q + 3'd1;
      end
   end

   always_ff @(posedge clk_1MHz) begin
      if (!rst) begin
         level_q  <= 3'(DEFAULT_LEVEL);
         off_q    <= 1'b0;
         rot_on_q <= 1'b1;
      end else begin
         level_q <= level_d;
         if (press[KEY_OFF]) off_q    <= ~off_q;
         if (press[KEY_ROT]) rot_on_q <= ~rot_on_q;
      end
   end

   assign display_off   = off_q;
   assign display_level = level_q;

   // --------------------------------------------------------- page seek FSM
   state_e           state_q;
   logic             dir_down_q;
   logic [SEL_W-1:0] cand_q;
   logic [SEL_W-1:0] tries_q;
   logic [SEL_W-1:0] page_sel_q;
   logic [ROT_W-1:0] rot_cnt_q;

   logic any_valid;
   logic rot_expire;
   logic start_seek;

   assign any_valid  = |page_valid;
   assign rot_expire = rot_on_q && (state_q == ST_IDLE) && (rot_cnt_q == ROT_LAST);
   // Presses arriving during SEEK are dropped because start_seek is only
   // looked at in IDLE.
   assign start_seek = next_req || prev_req || rot_expire ||
                       (!page_valid[page_sel_q] && any_valid);

   always_ff @(posedge clk_1MHz) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         dir_down_q <= 1'b0;
         cand_q     <= '0;
         tries_q    <= '0;
         page_sel_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_seek) begin
                  state_q    <= ST_SEEK;
                  dir_down_q <= prev_req;
                  cand_q     <= step_page(page_sel_q, prev_req);
                  tries_q    <= '0;
               end
            end
            ST_SEEK: begin
               if (page_valid[cand_q]) begin
                  page_sel_q <= cand_q;
                  state_q    <= ST_IDLE;
               end else if (tries_q == SEL_LAST) begin
                  // Full lap with nothing valid: keep the current page.
                  state_q <= ST_IDLE;
               end else begin
                  cand_q  <= step_page(cand_q, dir_down_q);
                  tries_q <= tries_q + SEL_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign page_sel = page_sel_q;

   // Rotate timer only advances while idle with auto-rotate on; manual paging
   // and toggling auto-rotate restart the period.
   always_ff @(posedge clk_1MHz) begin
      if (!rst) begin
         rot_cnt_q <= '0;
      end else if (press[KEY_NEXT] || press[KEY_PREV] || press[KEY_ROT] || rot_expire) begin
         rot_cnt_q <= '0;
      end else if (rot_on_q && state_q == ST_IDLE) begin
         rot_cnt_q <= rot_cnt_q + ROT_W'(1);
      end
   end

   // -------------------------------------------------------------- data path
   logic [31:0] value_q;
   logic [7:0]  dots_q, green_q, red_q;
   logic [7:0]  green_d, red_d;
   int          sel_idx;

   assign sel_idx = int'(page_sel_q);

   always_comb begin
      green_d = page_leds_green[8*sel_idx +: 8];
      red_d   = page_leds_red[8*sel_idx +: 8];
`ifdef TM1638_PAGER_INDICATOR_EN
      if (sel_idx < 8) red_d = 8'd1 << page_sel_q;
      if (rot_on_q)    green_d[7] = 1'b1;
`endif
   end

   always_ff @(posedge clk_1MHz) begin
      if (!rst || !any_valid) begin
         value_q <= '0;
         dots_q  <= '0;
         green_q <= '0;
         red_q   <= '0;
      end else begin
         value_q <= page_value[32*sel_idx +: 32];
         dots_q  <= page_dots[8*sel_idx +: 8];
         green_q <= green_d;
         red_q   <= red_d;
      end
   end

   assign display_value = value_q;
   assign dots          = dots_q;
   assign leds_green    = green_q;
   assign leds_red      = red_q;

endmodule : tm1638_display_pager

// File: tb/tb_tm1638_display_pager.sv
// -----------------------------------------------------------------------------
// tb_tm1638_display_pager
// Self-checking bench for tm1638_display_pager (default build) with
// N_PAGES=4, DEBOUNCE_CYCLES=4, ROTATE_CYCLES=50. Expected page indices and
// levels are queued when a key or page_valid change is driven and popped when
// the DUT output is compared.
// -----------------------------------------------------------------------------
module tb_tm1638_display_pager;
   import tm1638_pkg::*;

   localparam int N_PAGES = 4;

   localparam logic [7:0] M_NEXT   = 8'(1 << KEY_NEXT);
   localparam logic [7:0] M_PREV   = 8'(1 << KEY_PREV);
   localparam logic [7:0] M_DIM    = 8'(1 << KEY_DIM);
   localparam logic [7:0] M_BRIGHT = 8'(1 << KEY_BRIGHT);
   localparam logic [7:0] M_OFF    = 8'(1 << KEY_OFF);
   localparam logic [7:0] M_ROT    = 8'(1 << KEY_ROT);

   logic                  clk_1MHz = 1'b0;
   logic                  rst;
   logic [7:0]            keys_raw;
   logic [32*N_PAGES-1:0] page_value;
   logic [8*N_PAGES-1:0]  page_dots, page_leds_green, page_leds_red;
   logic [N_PAGES-1:0]    page_valid;
   logic                  display_off;
   logic [2:0]            display_level;
   logic [31:0]           display_value;
   logic [7:0]            dots, leds_green, leds_red;
   logic [1:0]            page_sel;
   logic [7:0]            key_press;

   int n_checks = 0;
   int n_fails  = 0;
   int exp_q[$];
   int k6_cnt   = 0;
   int k7_cnt   = 0;
   int low_cnt  = 0;

   always #5 clk_1MHz = ~clk_1MHz;

   tm1638_display_pager #(
      .N_PAGES         (N_PAGES),
      .DEBOUNCE_CYCLES (4),
      .ROTATE_CYCLES   (50),
      .DEFAULT_LEVEL   (3)
   ) dut (
      .clk_1MHz        (clk_1MHz),
      .rst             (rst),
      .keys_raw        (keys_raw),
      .page_value      (page_value),
      .page_dots       (page_dots),
      .page_leds_green (page_leds_green),
      .page_leds_red   (page_leds_red),
      .page_valid      (page_valid),
      .display_off     (display_off),
      .display_level   (display_level),
      .display_value   (display_value),
      .dots            (dots),
      .leds_green      (leds_green),
      .leds_red        (leds_red),
      .page_sel        (page_sel),
      .key_press       (key_press)
   );

   // Pulse counters for forwarded keys; consumed keys must never appear.
   always @(negedge clk_1MHz) begin
      if (key_press[7] === 1'b1) k7_cnt++;
      if (key_press[6] === 1'b1) k6_cnt++;
      if (rst === 1'b1 && key_press[5:0] !== 6'b0) low_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] val_of(int p);
      return 32'hC0DE_0000 | (32'(p) * 32'h0000_0101);
   endfunction
   function automatic logic [7:0] dots_of(int p);
      return 8'h10 + 8'(p);
   endfunction
   function automatic logic [7:0] green_of(int p);
      return 8'h20 + 8'(p);
   endfunction
   function automatic logic [7:0] red_of(int p);
      return 8'h30 + 8'(p);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk_1MHz);
   endtask

   task automatic press_key(input logic [7:0] mask);
      keys_raw = mask;
      tick(12);
      keys_raw = 8'h00;
      tick(12);
   endtask

   task automatic wait_page_change(input int max_cycles, output int cycles, output bit timed_out);
      logic [1:0] start;
      start     = page_sel;
      cycles    = 0;
      timed_out = 1'b1;
      while (cycles < max_cycles) begin
         tick(1);
         cycles++;
         if (page_sel !== start) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst        = 1'b0;
      keys_raw   = 8'h00;
      page_valid = 4'b1111;
      tick(3);
      n_checks++;
      if (page_sel !== 2'd0 || display_off !== 1'b0 || display_level !== 3'd3) begin
         n_fails++;
         $display("FAIL reset_ctrl: got sel=%0d off=%b level=%0d required sel=0 off=0 level=3",
                  page_sel, display_off, display_level);
      end
      n_checks++;
      if (display_value !== 32'd0 || dots !== 8'd0 || leds_green !== 8'd0 ||
          leds_red !== 8'd0 || key_press !== 8'd0) begin
         n_fails++;
         $display("FAIL reset_data: got value=%h dots=%h g=%h r=%h kp=%h required all zero",
                  display_value, dots, leds_green, leds_red, key_press);
      end
      rst = 1'b1;
      tick(1);
      n_checks++;
      if (display_value !== val_of(0) || dots !== dots_of(0) ||
          leds_green !== green_of(0) || leds_red !== red_of(0)) begin
         n_fails++;
         $display("FAIL reset_first_page: got value=%h dots=%h g=%h r=%h required %h %h %h %h",
                  display_value, dots, leds_green, leds_red,
                  val_of(0), dots_of(0), green_of(0), red_of(0));
      end
   endtask

   task automatic test_rotate();
      int cyc;
      bit to;
      int exp;
      exp_q.push_back(1);
      exp_q.push_back(2);
      exp_q.push_back(3);
      exp_q.push_back(0);
      for (int i = 0; i < 4; i++) begin
         wait_page_change(70, cyc, to);
         exp = exp_q.pop_front();
         n_checks++;
         if (to || page_sel !== 2'(exp)) begin
            n_fails++;
            $display("FAIL rotate_step%0d: got page_sel=%0d timeout=%b required %0d", i, page_sel, to, exp);
         end
         if (i > 0) begin
            n_checks++;
            if (cyc < 51 || cyc > 52) begin
               n_fails++;
               $display("FAIL rotate_period%0d: got %0d cycles required 51..52", i, cyc);
            end
         end
      end
      // Auto-rotate off: page must stay put well past a rotate period.
      press_key(M_ROT);
      tick(150);
      n_checks++;
      if (page_sel !== 2'd0) begin
         n_fails++;
         $display("FAIL rotate_stop: got page_sel=%0d required 0", page_sel);
      end
   endtask

   task automatic test_bounce();
      int exp;
      keys_raw = 8'h00;
      for (int i = 0; i < 5; i++) begin
         keys_raw[0] = ~keys_raw[0];
         tick(2);
      end
      keys_raw = M_NEXT;
      exp_q.push_back(1);
      tick(20);
      keys_raw = 8'h00;
      tick(20);
      exp = exp_q.pop_front();
      n_checks++;
      if (page_sel !== 2'(exp)) begin
         n_fails++;
         $display("FAIL bounce_one_seek: got page_sel=%0d required %0d", page_sel, exp);
      end
      n_checks++;
      if (display_value !== val_of(1)) begin
         n_fails++;
         $display("FAIL bounce_value: got %h required %h", display_value, val_of(1));
      end
   endtask

   task automatic test_skip();
      int exp;
      page_valid = 4'b1010;
      exp_q.push_back(3);
      press_key(M_NEXT);
      exp = exp_q.pop_front();
      n_checks++;
      if (page_sel !== 2'(exp)) begin
         n_fails++;
         $display("FAIL skip_next: got page_sel=%0d required %0d", page_sel, exp);
      end
      exp_q.push_back(1);
      press_key(M_NEXT);
      exp = exp_q.pop_front();
      n_checks++;
      if (page_sel !== 2'(exp)) begin
         n_fails++;
         $display("FAIL skip_wrap: got page_sel=%0d required %0d", page_sel, exp);
      end
      exp_q.push_back(3);
      press_key(M_PREV);
      exp = exp_q.pop_front();
      n_checks++;
      if (page_sel !== 2'(exp)) begin
         n_fails++;
         $display("FAIL skip_prev_wrap: got page_sel=%0d required %0d", page_sel, exp);
      end
      exp_q.push_back(3);
      press_key(M_NEXT | M_PREV);
      exp = exp_q.pop_front();
      n_checks++;
      if (page_sel !== 2'(exp)) begin
         n_fails++;
         $display("FAIL skip_conflict: got page_sel=%0d required %0d", page_sel, exp);
      end
      n_checks++;
      if (display_value !== val_of(3) || dots !== dots_of(3) ||
          leds_green !== green_of(3) || leds_red !== red_of(3)) begin
         n_fails++;
         $display("FAIL skip_data: got value=%h dots=%h g=%h r=%h required %h %h %h %h",
                  display_value, dots, leds_green, leds_red,
                  val_of(3), dots_of(3), green_of(3), red_of(3));
      end
   endtask

   task automatic test_level();
      int exp;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back((3 + i + 1 > 7) ? 7 : 3 + i + 1);
         press_key(M_BRIGHT);
         exp = exp_q.pop_front();
         n_checks++;
         if (display_level !== 3'(exp)) begin
            n_fails++;
            $display("FAIL level_up%0d: got %0d required %0d", i, display_level, exp);
         end
      end
      exp_q.push_back(7);
      press_key(M_DIM | M_BRIGHT);
      exp = exp_q.pop_front();
      n_checks++;
      if (display_level !== 3'(exp)) begin
         n_fails++;
         $display("FAIL level_conflict: got %0d required %0d", display_level, exp);
      end
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back((6 - i < 0) ? 0 : 6 - i);
         press_key(M_DIM);
         exp = exp_q.pop_front();
         n_checks++;
         if (display_level !== 3'(exp)) begin
            n_fails++;
            $display("FAIL level_down%0d: got %0d required %0d", i, display_level, exp);
         end
      end
      // Independent keys in one cycle: brighten and blank together.
      press_key(M_BRIGHT | M_OFF);
      n_checks++;
      if (display_level !== 3'd1 || display_off !== 1'b1) begin
         n_fails++;
         $display("FAIL level_off_combo: got level=%0d off=%b required level=1 off=1",
                  display_level, display_off);
      end
      press_key(M_OFF);
      n_checks++;
      if (display_off !== 1'b0) begin
         n_fails++;
         $display("FAIL off_toggle_back: got %b required 0", display_off);
      end
      press_key(M_OFF);
      press_key(8'h40);
      n_checks++;
      if (k6_cnt !== 1 || page_sel !== 2'd3) begin
         n_fails++;
         $display("FAIL key6_forward: got pulses=%0d page_sel=%0d required pulses=1 page_sel=3",
                  k6_cnt, page_sel);
      end
   endtask

   task automatic test_invalidate();
      int cyc;
      bit to;
      int exp;
      exp_q.push_back(0);
      page_valid = 4'b0111;
      wait_page_change(20, cyc, to);
      exp = exp_q.pop_front();
      n_checks++;
      if (to || page_sel !== 2'(exp)) begin
         n_fails++;
         $display("FAIL invalid_reselect: got page_sel=%0d timeout=%b required %0d", page_sel, to, exp);
      end
      exp_q.push_back(2);
      page_valid = 4'b0100;
      wait_page_change(20, cyc, to);
      exp = exp_q.pop_front();
      n_checks++;
      if (to || page_sel !== 2'(exp)) begin
         n_fails++;
         $display("FAIL invalid_skip: got page_sel=%0d timeout=%b required %0d", page_sel, to, exp);
      end
      tick(2);
      n_checks++;
      if (display_value !== val_of(2)) begin
         n_fails++;
         $display("FAIL invalid_value: got %h required %h", display_value, val_of(2));
      end
      page_valid = 4'b0000;
      tick(3);
      n_checks++;
      if (display_value !== 32'd0 || dots !== 8'd0 || leds_green !== 8'd0 || leds_red !== 8'd0) begin
         n_fails++;
         $display("FAIL empty_data: got value=%h dots=%h g=%h r=%h required all zero",
                  display_value, dots, leds_green, leds_red);
      end
      tick(30);
      n_checks++;
      if (page_sel !== 2'd2) begin
         n_fails++;
         $display("FAIL empty_hold: got page_sel=%0d required 2", page_sel);
      end
      page_valid = 4'b1111;
      tick(2);
      n_checks++;
      if (display_value !== val_of(2) || page_sel !== 2'd2) begin
         n_fails++;
         $display("FAIL empty_recover: got value=%h sel=%0d required %h sel=2",
                  display_value, page_sel, val_of(2));
      end
   endtask

   task automatic test_reset_mid_seek();
      int cyc;
      bit to;
      int exp;
      // Page 2 loses validity: the seek walks 3, 0, 1 and is cut by reset.
      keys_raw   = 8'h80;
      page_valid = 4'b0010;
      tick(1);
      rst = 1'b0;
      tick(1);
      n_checks++;
      if (page_sel !== 2'd0 || display_off !== 1'b0 || display_level !== 3'd3 ||
          display_value !== 32'd0 || dots !== 8'd0 || leds_green !== 8'd0 ||
          leds_red !== 8'd0 || key_press !== 8'd0) begin
         n_fails++;
         $display("FAIL reset_mid_seek: got sel=%0d off=%b lvl=%0d val=%h dots=%h g=%h r=%h kp=%h required 0 0 3 and zeros",
                  page_sel, display_off, display_level, display_value, dots,
                  leds_green, leds_red, key_press);
      end
      tick(2);
      k7_cnt = 0;
      exp_q.push_back(1);
      rst = 1'b1;
      wait_page_change(20, cyc, to);
      exp = exp_q.pop_front();
      n_checks++;
      if (to || page_sel !== 2'(exp)) begin
         n_fails++;
         $display("FAIL post_reset_seek: got page_sel=%0d timeout=%b required %0d", page_sel, to, exp);
      end
      tick(20);
      n_checks++;
      if (k7_cnt !== 1) begin
         n_fails++;
         $display("FAIL key7_pulse: got %0d pulses required 1", k7_cnt);
      end
      keys_raw = 8'h00;
      tick(10);
      n_checks++;
      if (low_cnt !== 0) begin
         n_fails++;
         $display("FAIL consumed_keys_hidden: got %0d cycles with key_press[5:0]!=0 required 0", low_cnt);
      end
   endtask

   initial begin
      for (int p = 0; p < N_PAGES; p++) begin
         page_value[32*p +: 32]    = val_of(p);
         page_dots[8*p +: 8]       = dots_of(p);
         page_leds_green[8*p +: 8] = green_of(p);
         page_leds_red[8*p +: 8]   = red_of(p);
      end
      test_reset();
      test_rotate();
      test_bounce();
      test_skip();
      test_level();
      test_invalidate();
      test_reset_mid_seek();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_tm1638_display_pager
